// File: rtl/display_scanner_pkg.sv
// Shared constants, frame payload type and digit helpers for the 4-digit multiplexed display scanner.
package display_scanner_pkg;

    localparam int unsigned NUM_DIGITS          = 4;
    localparam int unsigned NIBBLE_W            = 4;
    localparam int unsigned DATA_W              = NUM_DIGITS * NIBBLE_W;
    localparam int unsigned IDX_W               = 2;
    localparam int unsigned DEFAULT_REFRESH_DIV = 100000;
    localparam int unsigned DEFAULT_GUARD       = 16;

    // One displayable frame: four hex nibbles plus one decimal point per digit.
    typedef struct packed {
        logic [DATA_W-1:0]     digits;
        logic [NUM_DIGITS-1:0] dps;
    } frame_t;

    function automatic logic [NIBBLE_W-1:0] nibble_of(input frame_t f, input logic [IDX_W-1:0] idx);
        logic [NIBBLE_W-1:0] n;
        n = f.digits[32'(idx) * NIBBLE_W +: NIBBLE_W];
        return n;
    endfunction

    // Active-low enable pattern with only the selected digit driven.
    function automatic logic [NUM_DIGITS-1:0] anode_for(input logic [IDX_W-1:0] idx);
        logic [NUM_DIGITS-1:0] a;
        a      = '1;
        a[idx] = 1'b0;
        return a;
    endfunction

    // Leading zero: this digit and everything to its left is zero, and no decimal point here.
    function automatic logic digit_blanked(input frame_t f, input logic [IDX_W-1:0] idx);
        logic upper_zero;
        upper_zero = 1'b1;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (i >= 32'(idx) && f.digits[i * NIBBLE_W +: NIBBLE_W] != '0) begin
                upper_zero = 1'b0;
            end
        end
        return (idx != '0) && upper_zero && !f.dps[idx];
    endfunction

endpackage

// File: rtl/display_scanner.sv
// Time-multiplexed scanner for a 4-digit 7-segment display with ghosting guard,
// frame-synchronous data commit and optional leading-zero blanking.
module display_scanner
    import display_scanner_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = DEFAULT_REFRESH_DIV,
    parameter int unsigned GUARD       = DEFAULT_GUARD,
    parameter int unsigned LZ_BLANK    = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] data_in,
    input  logic [3:0]  dp_in,
    input  logic        load,
    output logic [3:0]  digit_value,
    output logic [3:0]  anode,
    output logic        dp,
    output logic        frame_start
);

    localparam int unsigned PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    logic [PW-1:0]    prescaler;
    logic [IDX_W-1:0] index;
    frame_t           shown;
    frame_t           pending;
    logic             pending_valid;

    logic [PW-1:0]    prescaler_d;
    logic [IDX_W-1:0] index_d;
    frame_t           shown_d;
    frame_t           pending_d;
    logic             pending_valid_d;
    frame_t           load_frame;
    logic             tick;
    logic             wrap;
    logic [3:0]       digit_value_d;
    logic [3:0]       anode_d;
    logic             dp_d;
    logic             frame_start_d;

    // Next-state: prescaler/index scan, commit policy and registered output values.
    always_comb begin
        prescaler_d       = prescaler + 1'b1;
        index_d           = index;
        shown_d           = shown;
        pending_d         = pending;
        pending_valid_d   = pending_valid;
        load_frame.digits = data_in;
        load_frame.dps    = dp_in;
        digit_value_d     = digit_value;
        dp_d              = dp;
        anode_d           = '1;

        tick          = (prescaler == PW'(REFRESH_DIV - 1));
        wrap          = tick && (index == IDX_W'(NUM_DIGITS - 1));
        frame_start_d = wrap;

        if (tick) begin
            prescaler_d = '0;
            index_d     = index + 1'b1;
        end

        // A load on the wrap edge goes straight to the display; otherwise it waits for the next wrap.
        if (wrap) begin
            if (load) begin
                shown_d = load_frame;
            end else if (pending_valid) begin
                shown_d = pending;
            end
            pending_valid_d = 1'b0;
        end else if (load) begin
            pending_d       = load_frame;
            pending_valid_d = 1'b1;
        end

        // Value and decimal point follow the new digit on the same edge the index moves.
        if (tick) begin
            digit_value_d = nibble_of(shown_d, index_d);
            dp_d          = ~shown_d.dps[index_d];
        end

        // Prescaler restarts at each index change, so it doubles as the guard timer.
        if (prescaler_d >= PW'(GUARD)) begin
            if (!((LZ_BLANK != 0) && digit_blanked(shown_d, index_d))) begin
                anode_d = anode_for(index_d);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prescaler     <= '0;
            index         <= '0;
            shown         <= '0;
            pending       <= '0;
            pending_valid <= 1'b0;
            digit_value   <= 4'h0;
            anode         <= 4'b1111;
            dp            <= 1'b1;
            frame_start   <= 1'b0;
        end else begin
            prescaler     <= prescaler_d;
            index         <= index_d;
            shown         <= shown_d;
            pending       <= pending_d;
            pending_valid <= pending_valid_d;
            digit_value   <= digit_value_d;
            anode         <= anode_d;
            dp            <= dp_d;
            frame_start   <= frame_start_d;
        end
    end

endmodule

// File: tb/tb_display_scanner.sv
// Directed bench for display_scanner: per-cycle frame expectations queued from data and compared on negedges.
module tb_display_scanner;

    localparam int RD    = 8;
    localparam int GD    = 2;
    localparam int FRAME = 4 * RD;

    typedef struct packed {
        logic [3:0] anode;
        logic [3:0] dv;
        logic       dp;
        logic       fs;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] data_in;
    logic [3:0]  dp_in;
    logic        load;
    logic [3:0]  digit_value;
    logic [3:0]  anode;
    logic        dp;
    logic        frame_start;

    int   total = 0;
    int   bad   = 0;
    exp_t sb[$];

    display_scanner #(.REFRESH_DIV(RD), .GUARD(GD), .LZ_BLANK(1)) dut (
        .clk        (clk),
        .reset      (reset),
        .data_in    (data_in),
        .dp_in      (dp_in),
        .load       (load),
        .digit_value(digit_value),
        .anode      (anode),
        .dp         (dp),
        .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(negedge clk);
        load = 1'b0;
    endtask

    // Expected outputs for one full frame, one entry per cycle starting at the frame_start cycle.
    task automatic push_frame(input logic [15:0] d, input logic [3:0] p);
        exp_t       e;
        logic [3:0] sel;
        logic       zero;
        logic       blank;
        for (int k = 0; k < 4; k++) begin
            for (int c = 0; c < RD; c++) begin
                sel    = 4'b1111;
                sel[k] = 1'b0;
                blank  = 1'b0;
                if (k >= 1) begin
                    zero = 1'b1;
                    for (int j = k; j < 4; j++) begin
                        if (d[j*4 +: 4] != 4'h0) zero = 1'b0;
                    end
                    blank = zero && !p[k];
                end
                e.anode = (c < GD || blank) ? 4'b1111 : sel;
                e.dv    = d[k*4 +: 4];
                e.dp    = ~p[k];
                e.fs    = (k == 0 && c == 0);
                sb.push_back(e);
            end
        end
    endtask

    // Waits for frame_start, then pops and compares one frame; optionally drives a load at cycle ld_at.
    task automatic check_frame(input int ld_at, input logic [15:0] ld_d, input logic [3:0] ld_p);
        exp_t e;
        bit   found;
        found = 1'b0;
        for (int w = 0; w < FRAME + 8 && !found; w++) begin
            step();
            if (frame_start === 1'b1) found = 1'b1;
        end
        if (!found) begin
            check("frame_start_wait", 16'(frame_start), 16'h1);
            sb.delete();
            return;
        end
        for (int c = 0; c < FRAME; c++) begin
            if (c != 0) step();
            e = sb.pop_front();
            check("anode",       16'(anode),       16'(e.anode));
            check("digit_value", 16'(digit_value), 16'(e.dv));
            check("dp",          16'(dp),          16'(e.dp));
            check("frame_start", 16'(frame_start), 16'(e.fs));
            if (c == ld_at) begin
                data_in = ld_d;
                dp_in   = ld_p;
                load    = 1'b1;
            end
        end
    endtask

    initial begin
        // Reset with a load held high: it must be ignored.
        reset   = 1'b1;
        load    = 1'b1;
        data_in = 16'h9999;
        dp_in   = 4'hF;
        repeat (3) @(negedge clk);
        check("rst_anode", 16'(anode),       16'hF);
        check("rst_dv",    16'(digit_value), 16'h0);
        check("rst_dp",    16'(dp),          16'h1);
        check("rst_fs",    16'(frame_start), 16'h0);

        reset = 1'b0;
        load  = 1'b0;
        step();
        check("rel_guard_anode", 16'(anode), 16'hF);
        step();
        check("rel_lit_anode", 16'(anode),       16'hE);
        check("rel_lit_dv",    16'(digit_value), 16'h0);
        check("rel_lit_dp",    16'(dp),          16'h1);

        data_in = 16'h1234;
        dp_in   = 4'h0;
        load    = 1'b1;

        // 1234 frame; ABCD loaded while digit 1 is selected must not disturb it.
        push_frame(16'h1234, 4'h0);
        check_frame(12, 16'hABCD, 4'h0);
        push_frame(16'hABCD, 4'h0);
        check_frame(5, 16'h0050, 4'h0);
        push_frame(16'h0050, 4'h0);
        check_frame(5, 16'h0000, 4'b0100);
        // Load 00FF exactly at the last cycle before the wrap edge.
        push_frame(16'h0000, 4'b0100);
        check_frame(FRAME - 1, 16'h00FF, 4'h0);
        push_frame(16'h00FF, 4'h0);
        check_frame(-1, 16'h0000, 4'h0);
        check("pending_after_direct", 16'(dut.pending_valid), 16'h0);

        // Wrap-coincident load of 1234, then mid-scan reset at digit 2 with a pending load in flight.
        data_in = 16'h1234;
        dp_in   = 4'h0;
        load    = 1'b1;
        step();
        check("wrap_load_fs", 16'(frame_start), 16'h1);
        check("wrap_load_dv", 16'(digit_value), 16'h4);
        for (int c = 1; c <= 20; c++) begin
            step();
            if (c == 10) begin
                data_in = 16'h5678;
                dp_in   = 4'hF;
                load    = 1'b1;
            end
        end
        check("idx2_anode", 16'(anode),       16'hB);
        check("idx2_dv",    16'(digit_value), 16'h2);
        reset = 1'b1;
        step();
        check("mid_rst_anode",   16'(anode),             16'hF);
        check("mid_rst_dv",      16'(digit_value),       16'h0);
        check("mid_rst_dp",      16'(dp),                16'h1);
        check("mid_rst_fs",      16'(frame_start),       16'h0);
        check("mid_rst_pending", 16'(dut.pending_valid), 16'h0);
        reset = 1'b0;
        step();
        check("rerun_guard_anode", 16'(anode), 16'hF);
        step();
        check("rerun_lit_anode", 16'(anode),       16'hE);
        check("rerun_lit_dv",    16'(digit_value), 16'h0);
        push_frame(16'h0000, 4'h0);
        check_frame(-1, 16'h0000, 4'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/display_scanner.md
DISPLAY_SCANNER -- requirements
Module: display_scanner

Interface
REQ-001 SHALL provide parameter REFRESH_DIV, default 100000, clock cycles each digit stays selected (>= 4).
REQ-002 SHALL provide parameter GUARD, default 16, all-anodes-off cycles after each digit switch (1 <= GUARD < REFRESH_DIV).
REQ-003 SHALL provide parameter LZ_BLANK, default 1, enables leading-zero blanking.
REQ-004 SHALL have port clk  input  1  system clock; the block uses this single clock.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port data_in  input  16  four hex nibbles; nibble i drives digit i, and digit 0 is rightmost.
REQ-007 SHALL have port dp_in  input  4  decimal-point request per digit, active-high.
REQ-008 SHALL have port load  input  1  single-cycle strobe that captures data_in and dp_in.
REQ-009 SHALL have port digit_value  output  4  nibble of the selected digit, which feeds the 7-segment decoder.
REQ-010 SHALL have port anode  output  4  digit enables, active-low, bit i = digit i.
REQ-011 SHALL have port dp  output  1  decimal point of the selected digit, active-low.
REQ-012 SHALL have port frame_start  output  1  one-cycle pulse when the scan returns to digit 0.

Function
REQ-013 SHALL count prescaler 0..REFRESH_DIV-1, then wrap to 0; tick = prescaler at REFRESH_DIV-1.
REQ-014 SHALL advance digit index 0->1->2->3->0 on each tick.
REQ-015 SHALL drive every output from registers, with no combinational path from any input to any output.
REQ-016 SHALL, on the clock edge where the index changes, update digit_value to nibble[new index] and dp to ~shown_dp[new index] on that same edge.
REQ-017 SHALL hold anode at 4'b1111 for the first GUARD cycles after each index change (ghosting guard), then drive anode = ~(1<<index) until the next tick.
REQ-018 SHALL capture data_in/dp_in into the pending registers when load=1 and set pending_valid; with multiple loads in one frame, the last load wins.
REQ-019 SHALL, on the tick that wraps index 3->0 with pending_valid=1, copy pending to the shown registers and clear pending_valid; shown data changes only at frame boundaries.
REQ-020 SHALL, when load coincides with a 3->0 wrap tick, commit data_in/dp_in directly to shown and leave pending_valid=0.
REQ-021 SHALL, with LZ_BLANK=1, hold anode[i] high for digit i>=1 while shown nibbles i..3 are all zero and shown_dp[i]=0; digit 0 is never blanked.
REQ-022 SHALL not suppress digit_value or advance the scan for blanked digits; blanking affects anode only.
REQ-023 SHALL pulse frame_start high for exactly one cycle on the edge where the index becomes 0.
REQ-024 SHALL ignore load while reset=1.

Reset
REQ-025 SHALL, on reset, clear prescaler=0, index=0, shown data=0, shown dp=0, pending=0, pending_valid=0.
REQ-026 SHALL, on reset, drive digit_value=4'h0, anode=4'b1111, dp=1, frame_start=0.
REQ-027 SHALL, after reset release, start the guard interval so that anode[0] asserts after GUARD cycles.
REQ-028 SHALL abandon an in-progress frame or pending load immediately on mid-scan reset, with no residual commit.

Structure
REQ-029 SHALL place NUM_DIGITS=4 and the default REFRESH_DIV/GUARD constants in the shared display package.
REQ-030 SHALL instantiate no sub-module; the top level pairs digit_value with the existing 7-segment decoder outside this block.

Verification
REQ-031 SHALL verify, with REFRESH_DIV=8, GUARD=2, and load 16'h1234 before the first wrap: after the first frame_start, anode sequence 1110,1101,1011,0111, each low for 6 cycles after 2 all-high cycles; digit_value 4,3,2,1.
REQ-032 SHALL verify that load 16'hABCD at mid-frame while showing 16'h1234 leaves digits 2..3 of the current frame as 2,1, with 16'hD first appearing after the next frame_start.
REQ-033 SHALL verify, with LZ_BLANK=1 and data 16'h0050, that anode[3] and anode[2] stay high all frame, and that digits 1 and 0 light with 5 and 0.
REQ-034 SHALL verify that load 16'h00FF coincident with the 3->0 tick shows digit_value=F on that edge, with pending_valid=0 afterwards.
REQ-035 SHALL verify that reset asserted at index 2 gives anode=1111, digit_value=0, dp=1, and frame_start=0 on the next edge, with the scan restarting at digit 0 after GUARD cycles.
REQ-036 SHALL verify that dp_in=4'b0100 with data 16'h0000 unblanks digit 2, giving dp=0 only while anode=1011.
